// File: rtl/uart_link_pkg.sv
// Shared definitions for the Host-PC <-> AWG serial link: frame field positions,
// broadcast ID, bit-level FSM state type and the frame checksum helper.
package uart_link_pkg;

  localparam int FRAME_BYTES = 8;

  localparam int AWG_ID_MSB = 63;
  localparam int AWG_ID_LSB = 59;
  localparam int CHAN_MSB   = 58;
  localparam int CHAN_LSB   = 55;
  localparam int ADDR_MSB   = 54;
  localparam int ADDR_LSB   = 40;
  localparam int DELAY_MSB  = 39;
  localparam int DELAY_LSB  = 8;
  localparam int CHK_MSB    = 7;
  localparam int CHK_LSB    = 0;

  localparam logic [4:0] BROADCAST_ID = 5'h1F;

  typedef enum logic [2:0] {
    BIT_IDLE,
    BIT_START,
    BIT_DATA,
    BIT_STOP,
    BIT_BREAK
  } bit_state_e;

  // Checksum is the XOR of the seven payload bytes ([63:56] down to [15:8]).
  function automatic logic [7:0] frame_chk(input logic [63:0] frame);
    logic [7:0] acc;
    acc = '0;
    for (int i = 1; i < FRAME_BYTES; i++) acc ^= frame[i*8 +: 8];
    return acc;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop input synchroniser, bit FSM and baud counter.
// Emits a byte-valid pulse, a framing-error pulse and an idle flag.
module uart_rx_byte
  import uart_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxb,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err,
  output logic       idle
);

  localparam int CNT_W = 12;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_meta, rx_sync;
  bit_state_e       state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;

  // NOTE: the synchroniser resets to 1 so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rxb;
      rx_sync <= rx_meta;
    end
  end

  // NOTE: all state uses non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BIT_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q + 1'b1;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (state_q)
      BIT_IDLE: begin
        // The line is always high on entry to IDLE, so a low level is a falling edge.
        baud_d = '0;
        bit_d  = '0;
        if (!rx_sync) state_d = BIT_START;
      end
      BIT_START: begin
        if (baud_q == HALF_M1) begin
          baud_d  = '0;
          state_d = rx_sync ? BIT_IDLE : BIT_DATA;
        end
      end
      BIT_DATA: begin
        if (baud_q == FULL_M1) begin
          baud_d  = '0;
          shreg_d = {rx_sync, shreg_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = BIT_STOP;
        end
      end
      BIT_STOP: begin
        if (baud_q == FULL_M1) begin
          baud_d = '0;
          if (rx_sync) begin
            byte_valid = 1'b1;
            state_d    = BIT_IDLE;
          end else begin
            frame_err = 1'b1;
            state_d   = BIT_BREAK;
          end
        end
      end
      BIT_BREAK: begin
        baud_d = '0;
        if (rx_sync) state_d = BIT_IDLE;
      end
      default: state_d = BIT_IDLE;
    endcase
  end

  assign byte_data = shreg_q;
  assign idle      = (state_q == BIT_IDLE);

endmodule

// File: rtl/uart_rx_delay_decoder.sv
// UART delay-RAM loader: assembles 8-byte frames, checks ID/channel and writes one
// delay RAM. Define UART_RX_CHKSUM_EN to enable the frame checksum check.
module uart_rx_delay_decoder
  import uart_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int NUM_CH       = 4,
  parameter int ADDR_W       = 11,
  parameter int DELAY_W      = 24,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic               I_clk_10M,
  input  logic               I_rst_n,
  input  logic               rxb,
  input  logic [4:0]         GA,
  output logic [NUM_CH-1:0]  O_wea,
  output logic [ADDR_W-1:0]  O_waddr,
  output logic [DELAY_W-1:0] O_wdata,
  output logic               O_frame_err,
  output logic [15:0]        O_err_cnt,
  output logic               O_busy
);

  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W     = (TO_LIMIT > 2) ? $clog2(TO_LIMIT) : 1;

  logic       rx_valid, rx_frame_err, rx_idle;
  logic [7:0] rx_data;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx_byte (
    .clk        (I_clk_10M),
    .rst_n      (I_rst_n),
    .rxb        (rxb),
    .byte_valid (rx_valid),
    .byte_data  (rx_data),
    .frame_err  (rx_frame_err),
    .idle       (rx_idle)
  );

  logic [55:0]     frame_q;
  logic [2:0]      byte_cnt_q;
  logic [TO_W-1:0] to_cnt_q;

  logic [63:0]       full_frame;
  logic [4:0]        awg_id;
  logic [3:0]        chan;
  logic              id_match, chan_ok, chk_ok;
  logic              last_byte, wr_fire, dec_err, timeout_hit, err_pulse;
  logic [NUM_CH-1:0] wea_d;
  logic              unused_frame_bits;

  // The eighth byte is decoded combinationally as it arrives so the write
  // lands one cycle after the last stop-bit sample.
  assign full_frame = {frame_q, rx_data};
  assign awg_id     = full_frame[AWG_ID_MSB:AWG_ID_LSB];
  assign chan       = full_frame[CHAN_MSB:CHAN_LSB];
  assign id_match   = (awg_id == GA) || (awg_id == BROADCAST_ID);
  assign chan_ok    = (int'(chan) < NUM_CH);

`ifdef UART_RX_CHKSUM_EN
  assign chk_ok = (full_frame[CHK_MSB:CHK_LSB] == frame_chk(full_frame));
`else
  assign chk_ok = 1'b1;
`endif

  assign unused_frame_bits = ^full_frame;

  assign last_byte   = rx_valid && (byte_cnt_q == 3'd7);
  assign wr_fire     = last_byte && id_match && chan_ok && chk_ok;
  assign dec_err     = last_byte && id_match && !(chan_ok && chk_ok);
  assign timeout_hit = rx_idle && O_busy && (to_cnt_q == TO_W'(TO_LIMIT - 1));
  assign err_pulse   = rx_frame_err || timeout_hit || dec_err;

  always_comb begin
    wea_d = '0;
    for (int i = 0; i < NUM_CH; i++) wea_d[i] = wr_fire && (chan == 4'(i));
  end

  always_ff @(posedge I_clk_10M) begin
    if (!I_rst_n) begin
      frame_q     <= '0;
      byte_cnt_q  <= '0;
      to_cnt_q    <= '0;
      O_wea       <= '0;
      O_waddr     <= '0;
      O_wdata     <= '0;
      O_frame_err <= 1'b0;
      O_err_cnt   <= '0;
    end else begin
      O_wea       <= wea_d;
      O_frame_err <= err_pulse;
      if (wr_fire) begin
        O_waddr <= full_frame[ADDR_LSB +: ADDR_W];
        O_wdata <= full_frame[DELAY_LSB +: DELAY_W];
      end
      if (err_pulse && (O_err_cnt != 16'hFFFF)) O_err_cnt <= O_err_cnt + 16'd1;

      // The byte count wraps 7 -> 0 on the eighth byte, closing the frame.
      if (rx_frame_err || timeout_hit) begin
        byte_cnt_q <= '0;
        frame_q    <= '0;
      end else if (rx_valid) begin
        byte_cnt_q <= byte_cnt_q + 3'd1;
        frame_q    <= {frame_q[47:0], rx_data};
      end

      if (rx_idle && O_busy && !timeout_hit) to_cnt_q <= to_cnt_q + 1'b1;
      else                                   to_cnt_q <= '0;
    end
  end

  assign O_busy = (byte_cnt_q != 3'd0);

endmodule

// File: tb/tb_uart_rx_delay_decoder.sv
// Directed bench for uart_rx_delay_decoder (CLKS_PER_BIT=8, NUM_CH=4, GA=14).
// Expectations follow UART_RX_CHKSUM_EN when it is defined for the build.
module tb_uart_rx_delay_decoder;

  localparam int CPB = 8;

  logic        clk;
  logic        rst_n;
  logic        rxb;
  logic [4:0]  ga;
  logic [3:0]  o_wea;
  logic [10:0] o_waddr;
  logic [23:0] o_wdata;
  logic        o_frame_err;
  logic [15:0] o_err_cnt;
  logic        o_busy;

  int checks = 0;
  int errors = 0;

  int          wr_cnt = 0;
  int          ferr_cnt = 0;
  int          wide_cnt = 0;
  logic        prev_wea_nz = 1'b0;
  logic [3:0]  last_wea = '0;
  logic [10:0] last_waddr = '0;
  logic [23:0] last_wdata = '0;

  int exp_wr = 0;
  int exp_ferr = 0;
  int exp_err = 0;

  logic [63:0] f;

  uart_rx_delay_decoder #(
    .CLKS_PER_BIT (CPB),
    .NUM_CH       (4),
    .ADDR_W       (11),
    .DELAY_W      (24),
    .TIMEOUT_BITS (20)
  ) dut (
    .I_clk_10M   (clk),
    .I_rst_n     (rst_n),
    .rxb         (rxb),
    .GA          (ga),
    .O_wea       (o_wea),
    .O_waddr     (o_waddr),
    .O_wdata     (o_wdata),
    .O_frame_err (o_frame_err),
    .O_err_cnt   (o_err_cnt),
    .O_busy      (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records write and error pulses; a write pulse wider than one cycle or not
  // one-hot is tallied in wide_cnt.
  always @(negedge clk) begin
    if (o_wea != 4'd0) begin
      wr_cnt     <= wr_cnt + 1;
      last_wea   <= o_wea;
      last_waddr <= o_waddr;
      last_wdata <= o_wdata;
      if (prev_wea_nz || !$onehot(o_wea)) wide_cnt <= wide_cnt + 1;
    end
    prev_wea_nz <= |o_wea;
    if (o_frame_err) ferr_cnt <= ferr_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_bits(input int n);
    repeat (n * CPB) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rxb = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rxb = b[i];
      repeat (CPB) @(posedge clk);
    end
    rxb = stop_bit;
    repeat (CPB) @(posedge clk);
    rxb = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic send_frame(input logic [63:0] fr);
    for (int i = 7; i >= 0; i--) send_byte(fr[i*8 +: 8], 1'b1);
  endtask

  function automatic logic [63:0] make_frame(input logic [4:0] id, input logic [3:0] ch,
                                             input logic [14:0] addr, input logic [31:0] dly,
                                             input logic bad_chk);
    logic [63:0] fr;
    logic [7:0]  c;
    fr = {id, ch, addr, dly, 8'h00};
    c  = 8'h00;
    for (int i = 1; i < 8; i++) c ^= fr[i*8 +: 8];
    fr[7:0] = bad_chk ? ~c : c;
    return fr;
  endfunction

  task automatic check_write(input string tag, input logic [3:0] wea,
                             input logic [10:0] addr, input logic [23:0] data);
    exp_wr++;
    check({tag, "_wr_cnt"}, 64'(wr_cnt), 64'(exp_wr));
    check({tag, "_wea"}, 64'(last_wea), 64'(wea));
    check({tag, "_waddr"}, 64'(last_waddr), 64'(addr));
    check({tag, "_wdata"}, 64'(last_wdata), 64'(data));
  endtask

  initial begin
    rst_n = 1'b0;
    rxb   = 1'b1;
    ga    = 5'd14;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_wea", 64'(o_wea), 64'h0);
    check("rst_waddr", 64'(o_waddr), 64'h0);
    check("rst_wdata", 64'(o_wdata), 64'h0);
    check("rst_frame_err", 64'(o_frame_err), 64'h0);
    check("rst_err_cnt", 64'(o_err_cnt), 64'h0);
    check("rst_busy", 64'(o_busy), 64'h0);
    rst_n = 1'b1;
    wait_bits(2);

    // Single write to channel 2
    send_frame(make_frame(5'd14, 4'd2, 15'd5, 32'd20, 1'b0));
    wait_bits(3);
    @(negedge clk);
    check_write("ch2", 4'b0100, 11'd5, 24'd20);
    check("ch2_err_cnt", 64'(o_err_cnt), 64'd0);
    check("ch2_hold_waddr", 64'(o_waddr), 64'd5);

    // One frame per channel
    for (int i = 0; i < 4; i++) begin
      send_frame(make_frame(5'd14, 4'(i), 15'(16 + i), 32'(10 * (i + 1)), 1'b0));
      wait_bits(3);
      @(negedge clk);
      check_write($sformatf("seq%0d", i), 4'(1 << i), 11'(16 + i), 24'(10 * (i + 1)));
    end

    // Foreign ID: silently dropped
    send_frame(make_frame(5'd3, 4'd1, 15'd1, 32'd1, 1'b0));
    wait_bits(3);
    @(negedge clk);
    check("foreign_wr_cnt", 64'(wr_cnt), 64'(exp_wr));
    check("foreign_ferr", 64'(ferr_cnt), 64'(exp_ferr));

    // Broadcast ID with over-wide address/delay fields (truncated)
    send_frame(make_frame(5'd31, 4'd1, 15'h7ABC, 32'h12345678, 1'b0));
    wait_bits(3);
    @(negedge clk);
    check_write("bcast", 4'b0010, 11'h2BC, 24'h345678);

    // Out-of-range channel
    send_frame(make_frame(5'd14, 4'd4, 15'd2, 32'd2, 1'b0));
    wait_bits(3);
    @(negedge clk);
    exp_ferr++;
    exp_err++;
    check("badch_wr_cnt", 64'(wr_cnt), 64'(exp_wr));
    check("badch_ferr", 64'(ferr_cnt), 64'(exp_ferr));
    check("badch_err_cnt", 64'(o_err_cnt), 64'(exp_err));

    // Corrupted checksum
    send_frame(make_frame(5'd14, 4'd0, 15'd33, 32'd44, 1'b1));
    wait_bits(3);
    @(negedge clk);
`ifdef UART_RX_CHKSUM_EN
    exp_ferr++;
    exp_err++;
    check("badchk_wr_cnt", 64'(wr_cnt), 64'(exp_wr));
`else
    check_write("badchk", 4'b0001, 11'd33, 24'd44);
`endif
    check("badchk_ferr", 64'(ferr_cnt), 64'(exp_ferr));
    check("badchk_err_cnt", 64'(o_err_cnt), 64'(exp_err));

    // Stop bit low on the third byte
    f = make_frame(5'd14, 4'd1, 15'd9, 32'd77, 1'b0);
    send_byte(f[63:56], 1'b1);
    send_byte(f[55:48], 1'b1);
    send_byte(f[47:40], 1'b0);
    wait_bits(3);
    @(negedge clk);
    exp_ferr++;
    exp_err++;
    check("stop_ferr", 64'(ferr_cnt), 64'(exp_ferr));
    check("stop_err_cnt", 64'(o_err_cnt), 64'(exp_err));
    check("stop_busy", 64'(o_busy), 64'd0);
    send_frame(f);
    wait_bits(3);
    @(negedge clk);
    check_write("after_stop", 4'b0010, 11'd9, 24'd77);

    // Inter-byte timeout after four bytes
    f = make_frame(5'd14, 4'd3, 15'd100, 32'd555, 1'b0);
    for (int i = 7; i >= 4; i--) send_byte(f[i*8 +: 8], 1'b1);
    @(negedge clk);
    check("to_busy_mid", 64'(o_busy), 64'd1);
    wait_bits(21);
    @(negedge clk);
    exp_ferr++;
    exp_err++;
    check("to_ferr", 64'(ferr_cnt), 64'(exp_ferr));
    check("to_err_cnt", 64'(o_err_cnt), 64'(exp_err));
    check("to_busy", 64'(o_busy), 64'd0);
    send_frame(f);
    wait_bits(3);
    @(negedge clk);
    check_write("after_to", 4'b1000, 11'd100, 24'd555);

    // Two-cycle glitch on the idle line
    rxb = 1'b0;
    repeat (2) @(posedge clk);
    rxb = 1'b1;
    wait_bits(4);
    @(negedge clk);
    check("glitch_wr_cnt", 64'(wr_cnt), 64'(exp_wr));
    check("glitch_ferr", 64'(ferr_cnt), 64'(exp_ferr));
    check("glitch_busy", 64'(o_busy), 64'd0);

    // Reset in the middle of byte 6
    f = make_frame(5'd14, 4'd0, 15'd7, 32'd99, 1'b0);
    for (int i = 7; i >= 3; i--) send_byte(f[i*8 +: 8], 1'b1);
    rxb = 1'b0;
    wait_bits(3);
    rst_n = 1'b0;
    rxb   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mrst_wea", 64'(o_wea), 64'h0);
    check("mrst_waddr", 64'(o_waddr), 64'h0);
    check("mrst_wdata", 64'(o_wdata), 64'h0);
    check("mrst_frame_err", 64'(o_frame_err), 64'h0);
    check("mrst_err_cnt", 64'(o_err_cnt), 64'h0);
    check("mrst_busy", 64'(o_busy), 64'h0);
    check("mrst_ferr", 64'(ferr_cnt), 64'(exp_ferr));
    rst_n = 1'b1;
    wait_bits(2);
    send_frame(f);
    wait_bits(3);
    @(negedge clk);
    check_write("after_rst", 4'b0001, 11'd7, 24'd99);
    check("after_rst_err_cnt", 64'(o_err_cnt), 64'd0);
    check("after_rst_ferr", 64'(ferr_cnt), 64'(exp_ferr));
    check("pulse_width", 64'(wide_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
